dma_copy_rc: RTL and testbench

- Bus initiator for the 7-bit ROM/SRAM address-decoded memory: address 0-63 is the ROM region, 64-127 is the SRAM region.
- On a start pulse, copies a block of bytes from any source address into the SRAM region.
- Reads use the memory's combinational read port; writes use its synchronous write port.
- Sits between a control register block and the memory decoder, and is the only driver of mem_addr, mem_we and mem_din.

---
 rtl/dma_copy_rc_pkg.sv | 20 ++
 rtl/dma_copy_rc_csum.sv | 44 ++++
 rtl/dma_copy_rc.sv | 181 ++++++++++++++++++
 tb/tb_dma_copy_rc.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dma_copy_rc_pkg.sv
// -----------------------------------------------------------------------------
// dma_copy_rc_pkg
// Shared definitions for the block-copy initiator: FSM state encoding,
// default bus widths and the memory-map constants of the 7-bit ROM/SRAM space.
// -----------------------------------------------------------------------------
package dma_copy_rc_pkg;

   localparam int AW_DEF        = 7;    // address width
   localparam int DW_DEF        = 8;    // data width
   localparam int SRAM_BASE_DEF = 64;   // lowest writable address
   localparam int ADDR_SPAN     = 128;  // size of the whole address space

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage : dma_copy_rc_pkg

// File: rtl/dma_copy_rc_csum.sv
// -----------------------------------------------------------------------------
// dma_copy_rc_csum
// Modulo-2^DW running byte sum of the bytes read during a copy.
// Only instantiated when DMA_COPY_RC_CHECKSUM_EN is defined.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   i_clr   in   clear the sum (accepted start)
//   i_en    in   add i_data into the sum this cycle
//   i_data  in   byte to accumulate
//   o_sum   out  current sum (registered)
// -----------------------------------------------------------------------------
module dma_copy_rc_csum
   import dma_copy_rc_pkg::*;
#(
   parameter int DW = DW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_en,
   input  logic [DW-1:0] i_data,
   output logic [DW-1:0] o_sum
);

   logic [DW-1:0] r_sum;

   // Accumulator: clear wins over accumulate; wraps naturally at 2^DW.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum <= {DW{1'b0}};
      end else if (i_clr) begin
         r_sum <= {DW{1'b0}};
      end else if (i_en) begin
         r_sum <= r_sum + i_data;
      end else begin
         r_sum <= r_sum;
      end
   end

   assign o_sum = r_sum;

endmodule : dma_copy_rc_csum

// File: rtl/dma_copy_rc.sv
// -----------------------------------------------------------------------------
// dma_copy_rc
// Bus initiator that copies a block of bytes from anywhere in the 7-bit
// ROM/SRAM space into the SRAM region, one byte per two cycles (RD then WR).
// Memory-side outputs decode only from registered state/pointers.
//
// Optional feature macro: DMA_COPY_RC_CHECKSUM_EN
//   defined   -> checksum accumulates every byte read (mod 256)
//   undefined -> checksum is tied to 0
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   one-cycle request, sampled only in IDLE
//   src_addr  in   first source address
//   dst_addr  in   first destination address
//   len       in   byte count (0..127)
//   mem_addr  out  address to the memory decoder
//   mem_we    out  write enable (only in WR)
//   mem_din   out  write data
//   mem_dout  in   combinational read data
//   busy      out  high in RD and WR
//   done      out  one-cycle completion pulse
//   err       out  sticky illegal-request flag, cleared by accepted start
//   checksum  out  running byte sum of read data
// -----------------------------------------------------------------------------
module dma_copy_rc
   import dma_copy_rc_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int SRAM_BASE = SRAM_BASE_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] src_addr,
   input  logic [AW-1:0] dst_addr,
   input  logic [AW-1:0] len,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [DW-1:0] mem_din,
   input  logic [DW-1:0] mem_dout,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [DW-1:0] checksum
);

   localparam logic [AW:0]   LP_SRAM_BASE = (AW+1)'(SRAM_BASE);
   localparam logic [AW:0]   LP_SPAN      = (AW+1)'(ADDR_SPAN);
   localparam logic [AW-1:0] LP_ONE       = AW'(1);

   state_t        r_state;
   state_t        w_next_state;
   logic [AW-1:0] r_src_ptr;
   logic [AW-1:0] r_dst_ptr;
   logic [AW-1:0] r_remain;
   logic [DW-1:0] r_data_q;
   logic          r_err;
   logic [AW:0]   w_dst_end;
   logic          w_illegal;
   logic          w_accept;

   // End address is computed one bit wider so a range running past the top
   // of the map is caught instead of wrapping into ROM.
   assign w_dst_end = {1'b0, dst_addr} + {1'b0, len};
   assign w_illegal = ({1'b0, dst_addr} < LP_SRAM_BASE) || (w_dst_end > LP_SPAN);
   assign w_accept  = (r_state == ST_IDLE) && start;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic: illegal and zero-length requests go straight to DONE.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               if (w_illegal || (len == {AW{1'b0}})) begin
                  w_next_state = ST_DONE;
               end else begin
                  w_next_state = ST_RD;
               end
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_RD:   w_next_state = ST_WR;
         ST_WR: begin
            if (r_remain == LP_ONE) begin
               w_next_state = ST_DONE;
            end else begin
               w_next_state = ST_RD;
            end
         end
         ST_DONE: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Datapath: request latch on accept, read capture in RD, pointer step in WR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src_ptr <= {AW{1'b0}};
         r_dst_ptr <= {AW{1'b0}};
         r_remain  <= {AW{1'b0}};
         r_data_q  <= {DW{1'b0}};
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_src_ptr <= src_addr;
                  r_dst_ptr <= dst_addr;
                  r_remain  <= len;
                  r_err     <= w_illegal;
               end
            end
            ST_RD: r_data_q <= mem_dout;
            ST_WR: begin
               r_src_ptr <= r_src_ptr + LP_ONE;   // wraps 127 -> 0
               r_dst_ptr <= r_dst_ptr + LP_ONE;
               r_remain  <= r_remain - LP_ONE;
            end
            default: begin
            end
         endcase
      end
   end

   // Output decode from registered state only.
   always_comb begin
      mem_addr = {AW{1'b0}};
      mem_we   = 1'b0;
      mem_din  = {DW{1'b0}};
      busy     = 1'b0;
      done     = 1'b0;
      case (r_state)
         ST_IDLE: begin
         end
         ST_RD: begin
            mem_addr = r_src_ptr;
            busy     = 1'b1;
         end
         ST_WR: begin
            mem_addr = r_dst_ptr;
            mem_we   = 1'b1;
            mem_din  = r_data_q;
            busy     = 1'b1;
         end
         ST_DONE: done = 1'b1;
         default: begin
         end
      endcase
   end

   assign err = r_err;

`ifdef DMA_COPY_RC_CHECKSUM_EN
   dma_copy_rc_csum #(
      .DW (DW)
   ) u_csum (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (w_accept),
      .i_en   (r_state == ST_RD),
      .i_data (mem_dout),
      .o_sum  (checksum)
   );
`else
   assign checksum = {DW{1'b0}};
`endif

endmodule : dma_copy_rc

// File: tb/tb_dma_copy_rc.sv
// -----------------------------------------------------------------------------
// tb_dma_copy_rc
// Self-checking bench: owns a 128-byte ROM/SRAM memory, drives directed and
// random copy requests, and compares the bus activity, timing, flags and final
// memory image against a byte-level reference of the copy rules.
// -----------------------------------------------------------------------------
module tb_dma_copy_rc;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [6:0] src_addr, dst_addr, len;
   logic [6:0] mem_addr;
   logic       mem_we;
   logic [7:0] mem_din, mem_dout;
   logic       busy, done, err;
   logic [7:0] checksum;

   logic [7:0] mem     [128];
   logic [7:0] ref_mem [128];
   logic       poke_en;
   logic [6:0] poke_addr;
   logic [7:0] poke_data;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       we;
      logic [6:0] addr;
      logic [7:0] din;
   } acc_t;

   acc_t q[$];

   dma_copy_rc dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .src_addr (src_addr),
      .dst_addr (dst_addr),
      .len      (len),
      .mem_addr (mem_addr),
      .mem_we   (mem_we),
      .mem_din  (mem_din),
      .mem_dout (mem_dout),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .checksum (checksum)
   );

   always #5 clk = ~clk;

   // Memory: combinational read, synchronous write, ROM below 64 ignores writes.
   assign mem_dout = mem[mem_addr];
   always @(posedge clk) begin
      if (poke_en) mem[poke_addr] <= poke_data;
      else if (mem_we && mem_addr >= 7'd64) mem[mem_addr] <= mem_din;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Bench-side memory load; call just after a negedge.
   task automatic poke(input logic [6:0] a, input logic [7:0] d);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(negedge clk);
      poke_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic mem_cmp();
      for (int i = 0; i < 128; i++) chk($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);
   endtask

   // One request. Called just after a negedge with the DUT idle; returns just
   // after a negedge with the DUT idle. mid_cyc: cycle to pulse a stray start;
   // abort_cyc: cycle in which reset is asserted (0 = none).
   task automatic run_copy(input logic [6:0] s, input logic [6:0] d, input logic [6:0] l,
                           input int mid_cyc, input int abort_cyc);
      logic       legal;
      logic [7:0] tmp [128];
      logic [7:0] exp_sum;
      logic [6:0] ra;
      acc_t       e;
      int         exp_cyc, nbytes, cyc, busy_cnt, we_cnt;
      bit         finished, aborted;

      legal   = (int'(d) >= 64) && (int'(d) + int'(l) <= 128);
      exp_sum = 8'd0;
      tmp     = ref_mem;
      q.delete();
      nbytes  = (abort_cyc > 0) ? (abort_cyc - 1) / 2 : int'(l);
      if (legal) begin
         for (int i = 0; i < int'(l); i++) begin
            ra = 7'((int'(s) + i) % 128);
            e.we = 1'b0; e.addr = ra; e.din = 8'd0;
            q.push_back(e);
            exp_sum = exp_sum + tmp[ra];
            e.we = 1'b1; e.addr = 7'(int'(d) + i); e.din = tmp[ra];
            q.push_back(e);
            tmp[e.addr] = e.din;
            if (i < nbytes) ref_mem[e.addr] = e.din;
         end
      end
`ifndef DMA_COPY_RC_CHECKSUM_EN
      exp_sum = 8'd0;
`endif
      exp_cyc = (legal && l != 7'd0) ? 2 * int'(l) + 1 : 1;

      src_addr = s; dst_addr = d; len = l; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; busy_cnt = 0; we_cnt = 0; finished = 0; aborted = 0;
      while (!finished && cyc <= exp_cyc + 8) begin
         if (done) begin
            chk("done_cyc", cyc, exp_cyc);
            chk("busy_cnt", busy_cnt, legal ? 2 * int'(l) : 0);
            chk("we_cnt", we_cnt, legal ? int'(l) : 0);
            chk("busy_at_done", busy, 1'b0);
            chk("we_at_done", mem_we, 1'b0);
            chk("err", err, !legal);
            chk("checksum", checksum, exp_sum);
            chk("acc_left", q.size(), 0);
            finished = 1;
         end else begin
            if (busy) busy_cnt++;
            if (mem_we) we_cnt++;
            chk("busy", busy, q.size() > 0);
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("we", mem_we, e.we);
               chk("addr", mem_addr, e.addr);
               if (e.we) chk("din", mem_din, e.din);
               if (cyc == 1) chk("err_cleared", err, 1'b0);
            end else begin
               chk("we_idle", mem_we, 1'b0);
            end
            if (cyc == abort_cyc) begin
               rst_n = 1'b0;
               #1;
               chk("rst_we", mem_we, 1'b0);
               chk("rst_addr", mem_addr, 7'd0);
               chk("rst_din", mem_din, 8'd0);
               chk("rst_busy", busy, 1'b0);
               chk("rst_done", done, 1'b0);
               chk("rst_err", err, 1'b0);
               chk("rst_csum", checksum, 8'd0);
               @(negedge clk);
               rst_n = 1'b1;
               finished = 1; aborted = 1;
            end
         end
         if (!finished) begin
            if (cyc == mid_cyc) begin
               start = 1'b1; src_addr = 7'($urandom); dst_addr = 7'd64; len = 7'd1;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      if (!finished) begin
         chk("timeout", 0, 1);
      end else if (!aborted) begin
         @(negedge clk);
         chk("done_pulse", done, 1'b0);
         chk("err_hold", err, !legal);
         chk("csum_hold", checksum, exp_sum);
      end
   endtask

   initial begin
      logic [7:0] fib [8];
      logic [6:0] s, d, l;
      fib = '{8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21};
      rst_n = 1'b0; start = 1'b0; poke_en = 1'b0; poke_addr = 7'd0; poke_data = 8'd0;
      src_addr = 7'd0; dst_addr = 7'd0; len = 7'd0;
      repeat (2) @(negedge clk);

      chk("reset_addr", mem_addr, 7'd0);
      chk("reset_we", mem_we, 1'b0);
      chk("reset_din", mem_din, 8'd0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_err", err, 1'b0);
      chk("reset_csum", checksum, 8'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 128; i++) poke(7'(i), (i < 8) ? fib[i] : 8'($urandom));

      run_copy(7'd0,   7'd64,  7'd8, 0, 0);   // Fibonacci block, checksum 54
      mem_cmp();
      run_copy(7'd0,   7'd10,  7'd4, 0, 0);   // destination in ROM
      run_copy(7'd126, 7'd120, 7'd4, 0, 0);   // source wraps 127 -> 0
      run_copy(7'd126, 7'd125, 7'd4, 0, 0);   // destination past the top
      run_copy(7'd0,   7'd64,  7'd0, 0, 0);   // zero length
      mem_cmp();

      for (int i = 64; i < 72; i++) poke(7'(i), 8'hAA);
      run_copy(7'd0, 7'd64, 7'd8, 3, 8);       // stray start, then reset mid-copy
      mem_cmp();

      run_copy(7'd0, 7'd10, 7'd4, 0, 0);       // leave err set
      run_copy(7'd4, 7'd100, 7'd3, 0, 0);      // back-to-back, checksum 26
      mem_cmp();

      for (int n = 0; n < 30; n++) begin
         s = 7'($urandom);
         if (n % 5 == 4) begin
            d = 7'($urandom);
            l = 7'($urandom);
         end else begin
            d = 7'(64 + $urandom_range(0, 63));
            l = 7'($urandom_range(0, 128 - int'(d)));
         end
         run_copy(s, d, l, (l >= 7'd2) ? 2 : 0, 0);
         mem_cmp();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_dma_copy_rc
